// File: rtl/nq_mem_pkg.sv
// Shared types/constants for the NanoQuarter memory-access path; no logic, no latency.
// State encoding is common to the controller and timeout counter; backpressure n/a.
package nq_mem_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int ADDR_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } mem_state_e;

    function automatic int tmo_cnt_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// BUSY-cycle watchdog: clears on BUSY entry, counts unacked BUSY cycles; expired_o is
// combinational in the last allowed cycle. No backpressure; an ack in that cycle suppresses expiry.
module mem_timeout_ctr
    import nq_mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic busy_i,
    input  logic ack_i,
    output logic expired_o
);

    localparam int                CNT_W = tmo_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (busy_i && !ack_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q == TIMEOUT-1 means this unacked cycle brings the count to TIMEOUT.
    assign expired_o = busy_i & ~ack_i & (cnt_q == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store responder with req/ack memory handshake; min load = 1 stall cycle, rdata 2 cycles after request.
// Stalls the pipeline while an access is outstanding; MEM_TIMEOUT_EN adds a sticky BUSY-timeout abort.
module mem_access_ctrl
    import nq_mem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRd_flg,
    input  logic              memWrt_flg,
    input  logic              nop_flg,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_flg,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_vld,
    output logic              err_flg
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_access_ctrl: TIMEOUT must be at least 1");
    end

    mem_state_e        state_q, state_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rdata_vld_q;

    logic new_req;
    logic load;
    logic busy;
    logic rd_done;
    logic expired;

    assign new_req = (memRd_flg | memWrt_flg) & ~nop_flg;
    assign busy    = (state_q == ST_BUSY);
    assign rd_done = busy & mem_ack & ~we_q;

`ifdef MEM_TIMEOUT_EN
    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (load),
        .busy_i    (busy),
        .ack_i     (mem_ack),
        .expired_o (expired)
    );
    assign err_flg = (state_q == ST_ERR);
`else
    assign expired = 1'b0;
    assign err_flg = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        stall_flg = 1'b0;
        load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (new_req) begin
                    stall_flg = 1'b1;
                    load      = 1'b1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Ack beats expiry when both land in the same cycle.
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    stall_flg = 1'b1;
                    if (expired) begin
                        state_d = ST_ERR;
                    end
                end
            end
`ifdef MEM_TIMEOUT_EN
            ST_ERR: begin
                state_d = ST_ERR;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rdata_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdata_vld_q <= rd_done;
            // Write wins when both request flags are set.
            if (load) begin
                we_q    <= memWrt_flg;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (rd_done) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_req   = busy;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign rdata_vld = rdata_vld_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: inputs driven 2 time units after the rising edge,
// outputs checked 1 unit later; timeout scenario depends on MEM_TIMEOUT_EN (TIMEOUT=4).
module tb_mem_access_ctrl;

    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          memRd_flg, memWrt_flg, nop_flg;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall_flg;
    logic [DW-1:0] rdata;
    logic          rdata_vld;
    logic          err_flg;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .memRd_flg  (memRd_flg),
        .memWrt_flg (memWrt_flg),
        .nop_flg    (nop_flg),
        .addr       (addr),
        .wdata      (wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .stall_flg  (stall_flg),
        .rdata      (rdata),
        .rdata_vld  (rdata_vld),
        .err_flg    (err_flg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; caller then drives and waits #1 to check.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        memRd_flg  = 1'b0;
        memWrt_flg = 1'b0;
        nop_flg    = 1'b0;
        mem_ack    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        addr      = '0;
        wdata     = '0;
        mem_rdata = '0;
        step();
        step();
        #1;
        chk("rst_req",   mem_req,   1'b0);
        chk("rst_we",    mem_we,    1'b0);
        chk("rst_addr",  mem_addr,  16'h0000);
        chk("rst_wdata", mem_wdata, 16'h0000);
        chk("rst_rdata", rdata,     16'h0000);
        chk("rst_vld",   rdata_vld, 1'b0);
        chk("rst_err",   err_flg,   1'b0);
        chk("rst_stall", stall_flg, 1'b0);
        rst = 1'b0;
        step();

        // Load, ack in first BUSY cycle
        memRd_flg = 1'b1; addr = 16'h0040;
        #1;
        chk("ld_n_stall", stall_flg, 1'b1);
        chk("ld_n_req",   mem_req,   1'b0);
        step();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        #1;
        chk("ld_n1_req",   mem_req,   1'b1);
        chk("ld_n1_we",    mem_we,    1'b0);
        chk("ld_n1_addr",  mem_addr,  16'h0040);
        chk("ld_n1_stall", stall_flg, 1'b0);
        step();
        idle_inputs(); mem_rdata = 16'h0000;
        #1;
        chk("ld_n2_vld",   rdata_vld, 1'b1);
        chk("ld_n2_rdata", rdata,     16'hBEEF);
        chk("ld_n2_req",   mem_req,   1'b0);
        chk("ld_n2_stall", stall_flg, 1'b0);
        step();
        #1;
        chk("ld_n3_vld",   rdata_vld, 1'b0);
        chk("ld_n3_rdata", rdata,     16'hBEEF);

        // Store, ack in third BUSY cycle
        memWrt_flg = 1'b1; addr = 16'h0012; wdata = 16'hA5A5;
        #1;
        chk("st_n_stall", stall_flg, 1'b1);
        for (int i = 1; i <= 2; i++) begin
            step();
            #1;
            chk($sformatf("st_b%0d_stall", i), stall_flg, 1'b1);
            chk($sformatf("st_b%0d_req", i),   mem_req,   1'b1);
            chk($sformatf("st_b%0d_we", i),    mem_we,    1'b1);
            chk($sformatf("st_b%0d_addr", i),  mem_addr,  16'h0012);
            chk($sformatf("st_b%0d_wdata", i), mem_wdata, 16'hA5A5);
        end
        step();
        mem_ack = 1'b1;
        #1;
        chk("st_b3_stall", stall_flg, 1'b0);
        chk("st_b3_wdata", mem_wdata, 16'hA5A5);
        step();
        idle_inputs();
        #1;
        chk("st_done_vld",  rdata_vld, 1'b0);
        chk("st_done_req",  mem_req,   1'b0);
        chk("st_done_we",   mem_we,    1'b1);
        chk("st_done_addr", mem_addr,  16'h0012);
        chk("st_done_rd",   rdata,     16'hBEEF);

        // Squashed load
        memRd_flg = 1'b1; nop_flg = 1'b1; addr = 16'h0099;
        #1;
        chk("nop_stall", stall_flg, 1'b0);
        step();
        #1;
        chk("nop_req",   mem_req,   1'b0);
        chk("nop_addr",  mem_addr,  16'h0012);
        idle_inputs();

        // Both flags: write wins; inputs change while BUSY
        memRd_flg = 1'b1; memWrt_flg = 1'b1; addr = 16'h1234; wdata = 16'h5678;
        #1;
        chk("both_stall", stall_flg, 1'b1);
        step();
        memWrt_flg = 1'b0; addr = 16'hFFFF; wdata = 16'h0000;
        #1;
        chk("both_we",    mem_we,    1'b1);
        chk("both_addr",  mem_addr,  16'h1234);
        chk("both_wdata", mem_wdata, 16'h5678);
        chk("both_stall1", stall_flg, 1'b1);
        step();
        mem_ack = 1'b1;
        #1;
        chk("both_ack_stall", stall_flg, 1'b0);
        chk("both_ack_addr",  mem_addr,  16'h1234);
        step();
        memRd_flg = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1111;
        #1;
        chk("both_vld",   rdata_vld, 1'b0);
        chk("spur_req0",  mem_req,   1'b0);
        step();
        mem_ack = 1'b0;
        #1;
        chk("spur_req1",   mem_req,   1'b0);
        chk("spur_stall",  stall_flg, 1'b0);
        chk("spur_vld",    rdata_vld, 1'b0);
        chk("spur_rdata",  rdata,     16'hBEEF);

        // Reset during second BUSY cycle
        memRd_flg = 1'b1; addr = 16'h0077;
        step();
        #1;
        chk("rb_b1_req", mem_req, 1'b1);
        step();
        memRd_flg = 1'b0; rst = 1'b1;
        #1;
        chk("rb_b2_req", mem_req, 1'b1);
        step();
        rst = 1'b0;
        #1;
        chk("rb_req",   mem_req,   1'b0);
        chk("rb_stall", stall_flg, 1'b0);
        chk("rb_addr",  mem_addr,  16'h0000);
        chk("rb_we",    mem_we,    1'b0);
        chk("rb_wdata", mem_wdata, 16'h0000);
        chk("rb_rdata", rdata,     16'h0000);
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        step();
        mem_ack = 1'b0;
        #1;
        chk("rb_late_vld",   rdata_vld, 1'b0);
        chk("rb_late_req",   mem_req,   1'b0);
        chk("rb_late_rdata", rdata,     16'h0000);
        chk("rb_late_err",   err_flg,   1'b0);

`ifdef MEM_TIMEOUT_EN
        // Ack in the 4th BUSY cycle completes normally
        memRd_flg = 1'b1; addr = 16'h0100;
        step();
        memRd_flg = 1'b0;
        step();
        step();
        step();
        mem_ack = 1'b1; mem_rdata = 16'hC0DE;
        #1;
        chk("tmo_lastack_req", mem_req, 1'b1);
        step();
        mem_ack = 1'b0;
        #1;
        chk("tmo_lastack_vld", rdata_vld, 1'b1);
        chk("tmo_lastack_rd",  rdata,     16'hC0DE);
        chk("tmo_lastack_err", err_flg,   1'b0);

        // No ack: abort after 4 BUSY cycles
        memRd_flg = 1'b1; addr = 16'h0200;
        for (int i = 1; i <= 4; i++) begin
            step();
            #1;
            chk($sformatf("tmo_b%0d_req", i),   mem_req,   1'b1);
            chk($sformatf("tmo_b%0d_stall", i), stall_flg, 1'b1);
        end
        step();
        #1;
        chk("tmo_err",    err_flg,   1'b1);
        chk("tmo_req",    mem_req,   1'b0);
        chk("tmo_stall",  stall_flg, 1'b0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        #1;
        chk("tmo_sticky",  err_flg,   1'b1);
        chk("tmo_ign_req", mem_req,   1'b0);
        chk("tmo_ign_stl", stall_flg, 1'b0);
        chk("tmo_ign_vld", rdata_vld, 1'b0);
        memRd_flg = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("tmo_rst_err", err_flg, 1'b0);
`else
        // Without the watchdog BUSY waits indefinitely
        memRd_flg = 1'b1; addr = 16'h0200;
        step();
        memRd_flg = 1'b0;
        for (int i = 0; i < 20; i++) step();
        #1;
        chk("notmo_req",   mem_req,   1'b1);
        chk("notmo_stall", stall_flg, 1'b1);
        chk("notmo_err",   err_flg,   1'b0);
        mem_ack = 1'b1; mem_rdata = 16'h4242;
        step();
        mem_ack = 1'b0;
        #1;
        chk("notmo_vld", rdata_vld, 1'b1);
        chk("notmo_rd",  rdata,     16'h4242);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-access controller for the NanoQuarter pipeline: the responder for the `memRd_flg`/`memWrt_flg` requests issued by main control. It latches each accepted load or store and runs a req/ack handshake with a multi-cycle data memory. It returns load data and drives the `stall_flg` that main control and the hazard path consume, holding the pipeline while an access is outstanding.

## Interface
- DATA_W, 16, data bus width
- ADDR_W, 16, address width
- TIMEOUT, 15, maximum BUSY cycles without `mem_ack` before abort (used only with MEM_TIMEOUT_EN)
- clk  input  1  pipeline clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- memRd_flg  input  1  load request from main control
- memWrt_flg  input  1  store request from main control
- nop_flg  input  1  current instruction squashed; request ignored
- addr  input  ADDR_W  effective address
- wdata  input  DATA_W  store data
- mem_req  output  1  memory request, held until ack
- mem_we  output  1  1 = write, 0 = read; stable while mem_req=1
- mem_addr  output  ADDR_W  latched address
- mem_wdata  output  DATA_W  latched store data
- mem_rdata  input  DATA_W  read data, valid with mem_ack
- mem_ack  input  1  access complete, single-cycle pulse
- stall_flg  output  1  freeze pipeline (combinational)
- rdata  output  DATA_W  registered load result
- rdata_vld  output  1  one-cycle pulse, rdata valid
- err_flg  output  1  sticky timeout error

## Operation
- States: IDLE, BUSY, ERR (ERR exists only with MEM_TIMEOUT_EN).
- new_req = (memRd_flg | memWrt_flg) & ~nop_flg.
- IDLE with new_req:
  - latch addr, wdata, and we = memWrt_flg.
  - go to BUSY.
  - If both flags are set, the write wins: we=1, no error.
- BUSY:
  - mem_req=1.
  - On mem_ack: go to IDLE. For reads, capture mem_rdata into rdata and pulse rdata_vld next cycle. Writes produce no rdata_vld.
- stall_flg = (IDLE & new_req) | (BUSY & ~mem_ack). The instruction stays presented while stalled, and the latched copy is authoritative. Request inputs are ignored while in BUSY.
- mem_ack in IDLE or ERR is ignored, with no state change.
- Request inputs are sampled again only in IDLE. Back-to-back accesses are therefore separated by at least one IDLE cycle.

## Timing
- Reset values:
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - rdata=0, rdata_vld=0, err_flg=0.
  - state=IDLE, timeout count=0.
  - stall_flg follows its equation from IDLE.
- Reset mid-BUSY: IDLE on the next edge. mem_req is 0 from that edge, no rdata_vld, and the access is abandoned.
- Minimum load: request in cycle N (stall=1); mem_req=1 in N+1; ack in N+1 (stall=0); rdata_vld=1 in N+2. This is one stall cycle.
- Each cycle of ack delay adds one stall cycle.
- mem_addr, mem_wdata, and mem_we change only on the IDLE→BUSY edge.

## Configuration
- MEM_TIMEOUT_EN defined:
  - The counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - At count==TIMEOUT without ack: go to ERR. mem_req=0, stall_flg=0, no rdata_vld, err_flg=1 (sticky).
  - ERR accepts no further requests and keeps stall_flg=0 until rst.
  - Ack on the cycle the count reaches TIMEOUT wins (normal completion).
- MEM_TIMEOUT_EN undefined: no counter and no ERR state. BUSY waits indefinitely, and err_flg is tied to 0.

## Structure
- Shared package `nq_mem_pkg`:
  - state enum (IDLE, BUSY, ERR).
  - default DATA_W/ADDR_W constants.
  - timeout counter width, $clog2(TIMEOUT+1).
- One sub-module: `mem_timeout_ctr`, holding the counter and expiry compare. It is instantiated only under MEM_TIMEOUT_EN.

## Test plan
- Load addr=0x0040; memory acks in the first BUSY cycle with 0xBEEF → stall for exactly 1 cycle, mem_we=0, rdata=0xBEEF with rdata_vld pulse in N+2.
- Store addr=0x0012, wdata=0xA5A5; ack after 3 cycles → mem_we=1, mem_addr/mem_wdata stable throughout, stall for 3 cycles, no rdata_vld.
- memRd_flg=1 with nop_flg=1 → mem_req stays 0, stall_flg=0.
- Both flags set; inputs change while BUSY → write issued with the originally latched addr/wdata; spurious ack in IDLE ignored.
- rst asserted in the 2nd BUSY cycle → mem_req=0 and stall_flg=0 after the edge, later ack ignored, all outputs at reset values.
- With MEM_TIMEOUT_EN, TIMEOUT=4 and no ack → mem_req drops after 4 BUSY cycles, err_flg=1 sticky, stall released, new requests ignored until rst.
